// File: rtl/delta_backprop_pkg.sv
// Shared fixed-point helpers and activation selector strings for the delta backprop stage.
package delta_backprop_pkg;

  localparam string ActRelu = "relu";
  localparam string ActNone = "none";

  // Q1.(WV-1): number of fractional bits removed after a WV x WV product.
  function automatic int unsigned frac_bits(input int unsigned wv);
    return wv - 1;
  endfunction

  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // One bit above 2*WV-1+clog2(NC) so that (-2^(WV-1))^2 terms summed NC times still fit.
  function automatic int unsigned acc_width(input int unsigned wv, input int unsigned nc);
    return 2 * wv + $clog2(nc);
  endfunction

endpackage

// File: rtl/delta_backprop_lane.sv
// One output lane: serial MAC over the reduction index, then shift, saturate and ReLU gate.
module delta_backprop_lane
  import delta_backprop_pkg::*;
#(
  parameter int unsigned WV   = 8,
  parameter int unsigned WA   = 2 * WV,
  parameter bit          Relu = 1'b1
) (
  input  logic                 iCLK,
  input  logic                 iRST,
  input  logic                 clr,
  input  logic                 en,
  input  logic                 fin,
  input  logic signed [WV-1:0] w,
  input  logic signed [WV-1:0] d1,
  input  logic signed [WV-1:0] y0,
  output logic        [WV-1:0] data
);

  localparam logic signed [WA-1:0] SatMax = WA'((1 << frac_bits(WV)) - 1);
  localparam logic signed [WA-1:0] SatMin = ~SatMax;

  logic signed [2*WV-1:0] prod;
  logic signed [WA-1:0]   acc_q;
  logic signed [WA-1:0]   acc_sum;
  logic signed [WA-1:0]   shifted;
  logic        [WV-1:0]   sat_val;
  logic        [WV-1:0]   gated;
  logic        [WV-1:0]   data_q;

  assign prod    = w * d1;
  assign acc_sum = acc_q + WA'(prod);
  // Arithmetic shift floors toward -inf.
  assign shifted = acc_sum >>> frac_bits(WV);

  always_comb begin
    if (shifted > SatMax) begin
      sat_val = SatMax[WV-1:0];
    end else if (shifted < SatMin) begin
      sat_val = SatMin[WV-1:0];
    end else begin
      sat_val = shifted[WV-1:0];
    end
    gated = sat_val;
    if (Relu && (y0[WV-1] || (y0 == '0))) begin
      gated = '0;
    end
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      acc_q  <= '0;
      data_q <= '0;
    end else begin
      if (clr) begin
        acc_q <= '0;
      end else if (en) begin
        acc_q <= acc_sum;
      end
      // fin coincides with the last en, so the final term is folded in via acc_sum.
      if (fin) begin
        data_q <= gated;
      end
    end
  end

  assign data = data_q;

endmodule

// File: rtl/delta_backprop.sv
// Backward-pass delta stage: delta0[p] = act'(y0[p]) * sum_c W[p][c]*delta1[c], NP lanes in parallel.
module delta_backprop
  import delta_backprop_pkg::*;
#(
  parameter int unsigned NP  = 4,
  parameter int unsigned NC  = 4,
  parameter int unsigned WV  = 4,
  parameter string       ACT = "relu"
) (
  input  logic                  iCLK,
  input  logic                  iRST,
  input  logic                  iValid_AS_Weight,
  output logic                  oReady_AS_Weight,
  input  logic [NP*NC*WV-1:0]   iData_AS_Weight,
  input  logic                  iValid_AS_Delta1,
  output logic                  oReady_AS_Delta1,
  input  logic [NC*WV-1:0]      iData_AS_Delta1,
  input  logic                  iValid_AS_State0,
  output logic                  oReady_AS_State0,
  input  logic [NP*WV-1:0]      iData_AS_State0,
  output logic                  oValid_BM_Delta0,
  input  logic                  iReady_BM_Delta0,
  output logic [NP*WV-1:0]      oData_BM_Delta0
);

  localparam int unsigned KW      = cnt_width(NC);
  localparam int unsigned WA      = acc_width(WV, NC);
  localparam bit          UseRelu = (ACT == ActRelu);

  typedef enum logic [1:0] {
    StIdle,
    StAcc,
    StOut
  } state_e;

  state_e                 state_q, state_d;
  logic   [KW-1:0]        k_q, k_d;
  logic                   valid_q, valid_d;
  logic   [NP*NC*WV-1:0]  w_q;
  logic   [NC*WV-1:0]     d1_q;
  logic   [NP*WV-1:0]     y0_q;
  logic                   accept;
  logic                   clr;
  logic                   en;
  logic                   fin;
  int                     k_idx;

  // Join: nothing is consumed unless all three operands are present at once.
  assign accept = ~iRST & (state_q == StIdle) &
                  iValid_AS_Weight & iValid_AS_Delta1 & iValid_AS_State0;

  assign oReady_AS_Weight = accept;
  assign oReady_AS_Delta1 = accept;
  assign oReady_AS_State0 = accept;
  assign oValid_BM_Delta0 = valid_q;

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    valid_d = valid_q;
    clr     = 1'b0;
    en      = 1'b0;
    fin     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          clr     = 1'b1;
          k_d     = '0;
          state_d = StAcc;
        end
      end
      StAcc: begin
        en = 1'b1;
        if (k_q == KW'(NC - 1)) begin
          fin     = 1'b1;
          k_d     = '0;
          valid_d = 1'b1;
          state_d = StOut;
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      StOut: begin
        if (valid_q && iReady_BM_Delta0) begin
          valid_d = 1'b0;
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state_q <= StIdle;
      k_q     <= '0;
      valid_q <= 1'b0;
      w_q     <= '0;
      d1_q    <= '0;
      y0_q    <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      valid_q <= valid_d;
      if (accept) begin
        w_q  <= iData_AS_Weight;
        d1_q <= iData_AS_Delta1;
        y0_q <= iData_AS_State0;
      end
    end
  end

  always_comb begin
    k_idx = int'(k_q);
  end

  for (genvar p = 0; p < NP; p++) begin : g_lane
    delta_backprop_lane #(
      .WV   (WV),
      .WA   (WA),
      .Relu (UseRelu)
    ) u_lane (
      .iCLK (iCLK),
      .iRST (iRST),
      .clr  (clr),
      .en   (en),
      .fin  (fin),
      .w    (w_q[(p * NC + k_idx) * WV +: WV]),
      .d1   (d1_q[k_idx * WV +: WV]),
      .y0   (y0_q[p * WV +: WV]),
      .data (oData_BM_Delta0[p * WV +: WV])
    );
  end

endmodule

// File: tb/tb_delta_backprop.sv
// Self-checking bench for delta_backprop (WV=8, NP=2, NC=3, ReLU) against a behavioural model.
module tb_delta_backprop;

  localparam int NP = 2;
  localparam int NC = 3;
  localparam int WV = 8;

  logic                  iCLK = 1'b0;
  logic                  iRST = 1'b1;
  logic                  iValid_AS_Weight = 1'b0;
  logic                  oReady_AS_Weight;
  logic [NP*NC*WV-1:0]   iData_AS_Weight = '0;
  logic                  iValid_AS_Delta1 = 1'b0;
  logic                  oReady_AS_Delta1;
  logic [NC*WV-1:0]      iData_AS_Delta1 = '0;
  logic                  iValid_AS_State0 = 1'b0;
  logic                  oReady_AS_State0;
  logic [NP*WV-1:0]      iData_AS_State0 = '0;
  logic                  oValid_BM_Delta0;
  logic                  iReady_BM_Delta0 = 1'b0;
  logic [NP*WV-1:0]      oData_BM_Delta0;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  bit rand_bp = 1'b0;

  delta_backprop #(
    .NP  (NP),
    .NC  (NC),
    .WV  (WV),
    .ACT ("relu")
  ) dut (
    .iCLK             (iCLK),
    .iRST             (iRST),
    .iValid_AS_Weight (iValid_AS_Weight),
    .oReady_AS_Weight (oReady_AS_Weight),
    .iData_AS_Weight  (iData_AS_Weight),
    .iValid_AS_Delta1 (iValid_AS_Delta1),
    .oReady_AS_Delta1 (oReady_AS_Delta1),
    .iData_AS_Delta1  (iData_AS_Delta1),
    .iValid_AS_State0 (iValid_AS_State0),
    .oReady_AS_State0 (oReady_AS_State0),
    .iData_AS_State0  (iData_AS_State0),
    .oValid_BM_Delta0 (oValid_BM_Delta0),
    .iReady_BM_Delta0 (iReady_BM_Delta0),
    .oData_BM_Delta0  (oData_BM_Delta0)
  );

  always #5 iCLK = ~iCLK;
  always @(posedge iCLK) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // delta0[p] = gate(y0[p]) * sat(floor(sum_c W[p][c]*d[c] / 2^(WV-1)))
  function automatic logic [NP*WV-1:0] model(input logic [NP*NC*WV-1:0] w,
                                             input logic [NC*WV-1:0] d,
                                             input logic [NP*WV-1:0] y);
    logic [NP*WV-1:0] r;
    logic signed [WV-1:0] wb, db, yb;
    int s;
    r = '0;
    for (int p = 0; p < NP; p++) begin
      s = 0;
      for (int c = 0; c < NC; c++) begin
        wb = w[(p * NC + c) * WV +: WV];
        db = d[c * WV +: WV];
        s  = s + int'(wb) * int'(db);
      end
      s = s >>> (WV - 1);
      if (s > 127) s = 127;
      if (s < -128) s = -128;
      yb = y[p * WV +: WV];
      if (int'(yb) <= 0) s = 0;
      r[p * WV +: WV] = 8'(s);
    end
    return r;
  endfunction

  // Reference model: tracks when the block may accept and when a result must appear.
  bit               m_idle = 1'b1;
  bit               m_valid = 1'b0;
  int               m_cnt = 0;
  logic [NP*WV-1:0] m_data = '0;
  logic [NP*WV-1:0] m_pend = '0;
  bit               exp_rdy;

  initial begin
    @(posedge iCLK);
    forever begin
      @(negedge iCLK);
      exp_rdy = !iRST && m_idle && iValid_AS_Weight && iValid_AS_Delta1 && iValid_AS_State0;
      chk("ready", {29'd0, oReady_AS_Weight, oReady_AS_Delta1, oReady_AS_State0},
          {29'd0, {3{exp_rdy}}});
      chk("valid", {31'd0, oValid_BM_Delta0}, {31'd0, m_valid});
      if (m_valid) chk("data", {16'd0, oData_BM_Delta0}, {16'd0, m_data});
      if (iRST) begin
        m_idle  = 1'b1;
        m_valid = 1'b0;
        m_cnt   = 0;
      end else if (exp_rdy) begin
        m_pend = model(iData_AS_Weight, iData_AS_Delta1, iData_AS_State0);
        m_idle = 1'b0;
        m_cnt  = NC;
      end else if (m_cnt > 0) begin
        m_cnt = m_cnt - 1;
        if (m_cnt == 0) begin
          m_valid = 1'b1;
          m_data  = m_pend;
        end
      end else if (m_valid && iReady_BM_Delta0) begin
        m_valid = 1'b0;
        m_idle  = 1'b1;
      end
    end
  end

  initial begin
    forever begin
      @(posedge iCLK);
      #1;
      if (rand_bp) iReady_BM_Delta0 = ($urandom % 3) != 0;
    end
  end

  task automatic set_valids(input bit v);
    iValid_AS_Weight = v;
    iValid_AS_Delta1 = v;
    iValid_AS_State0 = v;
  endtask

  // Present an item with all valids high and return one cycle after the accept edge (+#1).
  task automatic offer(input logic [NP*NC*WV-1:0] w, input logic [NC*WV-1:0] d,
                       input logic [NP*WV-1:0] y);
    bit got;
    got = 1'b0;
    iData_AS_Weight = w;
    iData_AS_Delta1 = d;
    iData_AS_State0 = y;
    set_valids(1'b1);
    for (int i = 0; i < 40; i++) begin
      @(negedge iCLK);
      if (oReady_AS_Weight === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
    chk("accept", {31'd0, got}, 32'd1);
    @(posedge iCLK);
    #1;
    set_valids(1'b0);
  endtask

  task automatic wait_out(input logic [NP*WV-1:0] exp, input int hold);
    int lat;
    bit seen;
    lat  = 0;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge iCLK);
      #1;
      lat++;
      if (oValid_BM_Delta0 === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    chk("out_seen", {31'd0, seen}, 32'd1);
    chk("latency", lat, NC);
    chk("out_literal", {16'd0, oData_BM_Delta0}, {16'd0, exp});
    if (hold > 0) begin
      iData_AS_Weight = '1;
      iData_AS_Delta1 = '1;
      iData_AS_State0 = '1;
      set_valids(1'b1);
      repeat (hold) begin
        @(posedge iCLK);
        #1;
      end
      chk("hold_valid", {31'd0, oValid_BM_Delta0}, 32'd1);
      chk("hold_data", {16'd0, oData_BM_Delta0}, {16'd0, exp});
      set_valids(1'b0);
    end
    iReady_BM_Delta0 = 1'b1;
    @(posedge iCLK);
    #1;
    iReady_BM_Delta0 = 1'b0;
    chk("handshake_clears", {31'd0, oValid_BM_Delta0}, 32'd0);
  endtask

  logic [NP*NC*WV-1:0] w_a, w_b, w_r;
  logic [NC*WV-1:0]    d_a, d_b, d_r;
  logic [NP*WV-1:0]    y_a, y_b, y_r;
  int hs_edge, acc_edge;
  bit got_b, seen_b;

  initial begin
    repeat (3) @(posedge iCLK);
    #1;
    chk("reset_valid", {31'd0, oValid_BM_Delta0}, 32'd0);
    chk("reset_data", {16'd0, oData_BM_Delta0}, 32'd0);
    iRST = 1'b0;

    // Pin the model with hand-computed values.
    chk("model_basic", {16'd0, model({6{8'd64}}, {3{8'd64}}, {8'd10, 8'd10})}, 32'h6060);
    chk("model_possat", {16'd0, model({6{8'd127}}, {3{8'd127}}, {8'd1, 8'd1})}, 32'h7f7f);
    chk("model_negsat", {16'd0, model({{3{8'd5}}, {3{8'h80}}}, {3{8'd127}}, {8'd0, 8'd5})},
        32'h0080);

    // Basic, positive saturation, negative saturation with a gated lane.
    offer({6{8'd64}}, {3{8'd64}}, {8'd10, 8'd10});
    wait_out(16'h6060, 0);
    offer({6{8'd127}}, {3{8'd127}}, {8'd3, 8'd1});
    wait_out(16'h7f7f, 0);
    offer({{3{8'd5}}, {3{8'h80}}}, {3{8'd127}}, {8'd0, 8'd5});
    wait_out(16'h0080, 0);

    // Join: valids rise one at a time; backpressure held for 5 cycles.
    iValid_AS_Weight = 1'b1;
    @(negedge iCLK);
    chk("join_one", {29'd0, oReady_AS_Weight, oReady_AS_Delta1, oReady_AS_State0}, 32'd0);
    @(posedge iCLK);
    #1;
    iValid_AS_Delta1 = 1'b1;
    @(negedge iCLK);
    chk("join_two", {29'd0, oReady_AS_Weight, oReady_AS_Delta1, oReady_AS_State0}, 32'd0);
    @(posedge iCLK);
    #1;
    offer({6{8'd64}}, {3{8'd64}}, {8'd20, 8'hfd});
    wait_out(16'h6000, 5);

    // Reset while k=1, then a clean item.
    offer({6{8'd127}}, {3{8'd127}}, {8'd3, 8'd1});
    @(posedge iCLK);
    #1;
    iRST = 1'b1;
    set_valids(1'b1);
    @(posedge iCLK);
    #1;
    iRST = 1'b0;
    set_valids(1'b0);
    chk("midreset_valid", {31'd0, oValid_BM_Delta0}, 32'd0);
    chk("midreset_data", {16'd0, oData_BM_Delta0}, 32'd0);
    offer({6{8'd64}}, {3{8'd64}}, {8'd10, 8'd10});
    wait_out(16'h6060, 0);

    // Back-to-back with the sink always ready.
    w_a = {8'd10, 8'd20, 8'd30, 8'hf0, 8'd100, 8'd7};
    d_a = {8'd90, 8'h85, 8'd44};
    y_a = {8'd1, 8'd1};
    w_b = {8'h81, 8'd2, 8'd50, 8'd60, 8'd70, 8'd80};
    d_b = {8'd127, 8'd127, 8'h90};
    y_b = {8'd9, 8'd9};
    iReady_BM_Delta0 = 1'b1;
    offer(w_a, d_a, y_a);
    iData_AS_Weight = w_b;
    iData_AS_Delta1 = d_b;
    iData_AS_State0 = y_b;
    set_valids(1'b1);
    hs_edge  = -100;
    acc_edge = 0;
    got_b    = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge iCLK);
      if (oValid_BM_Delta0 === 1'b1) begin
        chk("b2b_first", {16'd0, oData_BM_Delta0}, {16'd0, model(w_a, d_a, y_a)});
        hs_edge = cyc + 1;
      end
      if (oReady_AS_Weight === 1'b1) begin
        acc_edge = cyc + 1;
        got_b    = 1'b1;
        break;
      end
    end
    chk("b2b_accept", {31'd0, got_b}, 32'd1);
    chk("b2b_gap", acc_edge - hs_edge, 32'd1);
    @(posedge iCLK);
    #1;
    set_valids(1'b0);
    seen_b = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge iCLK);
      if (oValid_BM_Delta0 === 1'b1) begin
        seen_b = 1'b1;
        chk("b2b_second", {16'd0, oData_BM_Delta0}, {16'd0, model(w_b, d_b, y_b)});
        break;
      end
    end
    chk("b2b_second_seen", {31'd0, seen_b}, 32'd1);
    @(posedge iCLK);
    #1;
    iReady_BM_Delta0 = 1'b0;

    // Randomised items with dropping valids and random backpressure.
    rand_bp = 1'b1;
    for (int n = 0; n < 40; n++) begin
      bit got;
      w_r[31:0]  = $urandom;
      w_r[47:32] = 16'($urandom);
      d_r        = 24'($urandom);
      y_r        = 16'($urandom);
      if (n % 5 == 0) y_r[7:0] = 8'd0;
      got = 1'b0;
      for (int i = 0; i < 200; i++) begin
        @(posedge iCLK);
        #1;
        iData_AS_Weight  = w_r;
        iData_AS_Delta1  = d_r;
        iData_AS_State0  = y_r;
        iValid_AS_Weight = ($urandom % 4) != 0;
        iValid_AS_Delta1 = ($urandom % 4) != 0;
        iValid_AS_State0 = ($urandom % 4) != 0;
        @(negedge iCLK);
        if (oReady_AS_Weight === 1'b1) begin
          got = 1'b1;
          break;
        end
      end
      chk("rand_accept", {31'd0, got}, 32'd1);
      @(posedge iCLK);
      #1;
      set_valids(1'b0);
    end
    rand_bp = 1'b0;
    @(posedge iCLK);
    #2;
    iReady_BM_Delta0 = 1'b1;
    repeat (20) @(posedge iCLK);
    #1;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
